// File: rtl/int_ctrl_pkg.sv
// Shared types and helpers for the interrupt request controller.
// Holds the FSM state enum, default source count and a priority encoder.
package int_ctrl_pkg;

  localparam int NUM_SRC_DEF = 3;
  localparam int PRIO_W      = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // One-hot mask of the highest set bit of v (0 if v is 0).
  function automatic logic [PRIO_W-1:0] prio_hi(
    input logic [PRIO_W-1:0] v
  );
    logic [PRIO_W-1:0] r;
    r = '0;
    for (int i = 0; i < PRIO_W; i++) begin
      if (v[i]) r = PRIO_W'(1) << i;
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchroniser (SYNC_FF flops) plus rising-edge pulse.
// Ports: clk, rst_n, i_irq (async level), o_rise (1-cycle pulse).
module irq_sync_edge #(
  parameter int SYNC_FF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_irq,
  output logic o_rise
);

  logic [SYNC_FF-1:0] r_sync;
  logic               r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_FF-2:0], i_irq};
      r_prev <= r_sync[SYNC_FF-1];
    end
  end

  assign o_rise = r_sync[SYNC_FF-1] & ~r_prev;

endmodule

// File: rtl/int_request_ctrl.sv
// Interrupt request controller beside ID: sync, pend, arbitrate, enter, uret.
// Ports: clk, rst_n, irq_raw, int_gie, pipe_en, uret_ex -> Int_Enter, IRS,
// in_service, pending. Optional nesting enabled by macro INT_NEST_EN.
module int_request_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int SYNC_FF = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_raw,
  input  logic               int_gie,
  input  logic               pipe_en,
  input  logic               uret_ex,
  output logic               Int_Enter,
  output logic [NUM_SRC-1:0] IRS,
  output logic [NUM_SRC-1:0] in_service,
  output logic [NUM_SRC-1:0] pending
);

  state_e             r_state;
  logic [NUM_SRC-1:0] r_irs;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_isv;

  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_avail;
  logic [NUM_SRC-1:0] w_cand;
  logic [NUM_SRC-1:0] w_is_top;
  logic [NUM_SRC-1:0] w_is_pop;
  logic               w_elig;

  state_e             w_state_nxt;
  logic [NUM_SRC-1:0] w_irs_nxt;
  logic [NUM_SRC-1:0] w_isv_nxt;
  logic [NUM_SRC-1:0] w_pclr;
  logic [NUM_SRC-1:0] w_pend_nxt;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
    irq_sync_edge #(
      .SYNC_FF (SYNC_FF)
    ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_irq  (irq_raw[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_avail  = r_pend & ~r_isv;
  assign w_cand   = NUM_SRC'(prio_hi(PRIO_W'(w_avail)));
  assign w_is_top = NUM_SRC'(prio_hi(PRIO_W'(r_isv)));
  assign w_is_pop = r_isv & ~w_is_top;

`ifdef INT_NEST_EN
  // One-hot masks compare numerically by bit position.
  assign w_elig = int_gie & (|w_cand) & (w_cand > w_is_top);
`else
  assign w_elig = int_gie & (|w_cand) & ~(|r_isv);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_irs_nxt   = r_irs;
    w_isv_nxt   = r_isv;
    w_pclr      = '0;
    unique case (r_state)
      IDLE: begin
        if (w_elig) begin
          w_state_nxt = ENTER;
          w_irs_nxt   = w_cand;
        end
      end
      ENTER: begin
        // Entry is committed; gie and uret are ignored here.
        if (pipe_en) begin
          w_state_nxt = SERVICE;
          w_pclr      = r_irs;
          w_isv_nxt   = r_isv | r_irs;
          w_irs_nxt   = '0;
        end
      end
      SERVICE: begin
        // uret wins over a same-cycle request.
        if (uret_ex) begin
          w_isv_nxt = w_is_pop;
          if (~(|w_is_pop)) w_state_nxt = IDLE;
        end
`ifdef INT_NEST_EN
        else if (w_elig) begin
          w_state_nxt = ENTER;
          w_irs_nxt   = w_cand;
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_irs_nxt   = '0;
      end
    endcase
  end

  // A fresh edge on the source being taken re-arms it.
  assign w_pend_nxt = (r_pend & ~w_pclr) | w_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_irs   <= '0;
      r_pend  <= '0;
      r_isv   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_irs   <= w_irs_nxt;
      r_pend  <= w_pend_nxt;
      r_isv   <= w_isv_nxt;
    end
  end

  assign Int_Enter  = (r_state == ENTER);
  assign IRS        = r_irs;
  assign in_service = r_isv;
  assign pending    = r_pend;

endmodule

// File: tb/tb_int_request_ctrl.sv
// Self-checking bench for int_request_ctrl.
// Table-driven per-cycle vectors plus nesting and async-reset sequences.
module tb_int_request_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] irq_raw;
  logic       int_gie;
  logic       pipe_en;
  logic       uret_ex;
  logic       Int_Enter;
  logic [2:0] IRS;
  logic [2:0] in_service;
  logic [2:0] pending;

  int checks;
  int errors;

  int_request_ctrl #(
    .NUM_SRC (3),
    .SYNC_FF (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_raw    (irq_raw),
    .int_gie    (int_gie),
    .pipe_en    (pipe_en),
    .uret_ex    (uret_ex),
    .Int_Enter  (Int_Enter),
    .IRS        (IRS),
    .in_service (in_service),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] irq;
    logic       gie;
    logic       pe;
    logic       uret;
    logic       en;
    logic [2:0] irs;
    logic [2:0] isv;
    logic [2:0] pend;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic [2:0] irq, input logic gie,
    input logic pe, input logic uret,
    input logic en, input logic [2:0] irs,
    input logic [2:0] isv, input logic [2:0] pend
  );
    vec_t v;
    v.irq = irq; v.gie = gie; v.pe = pe; v.uret = uret;
    v.en = en; v.irs = irs; v.isv = isv; v.pend = pend;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [2:0] act,
                     input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic en,
                         input logic [2:0] irs, input logic [2:0] isv,
                         input logic [2:0] pend);
    chk({tag, ".Int_Enter"}, {2'b0, Int_Enter}, {2'b0, en});
    chk({tag, ".IRS"}, IRS, irs);
    chk({tag, ".in_service"}, in_service, isv);
    chk({tag, ".pending"}, pending, pend);
  endtask

  // Drive at negedge, sample 1ns after the following posedge.
  task automatic cyc(input logic [2:0] irq, input logic gie,
                     input logic pe, input logic uret);
    @(negedge clk);
    irq_raw = irq; int_gie = gie; pipe_en = pe; uret_ex = uret;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    irq_raw = '0; int_gie = 1'b1; pipe_en = 1'b1; uret_ex = 1'b0;

    // single pulse on source 0
    vq.push_back(mk(3'b001,1,1,0, 0,3'b000,3'b000,3'b000));
    vq.push_back(mk(3'b000,1,1,0, 0,3'b000,3'b000,3'b000));
    vq.push_back(mk(3'b000,1,1,0, 0,3'b000,3'b000,3'b001));
    vq.push_back(mk(3'b000,1,1,0, 1,3'b001,3'b000,3'b001));
    vq.push_back(mk(3'b000,1,1,0, 0,3'b000,3'b001,3'b000));
    vq.push_back(mk(3'b000,1,1,1, 0,3'b000,3'b000,3'b000));
    // sources 2 and 0 together: priority, then stall in ENTER
    vq.push_back(mk(3'b101,1,1,0, 0,3'b000,3'b000,3'b000));
    vq.push_back(mk(3'b000,1,1,0, 0,3'b000,3'b000,3'b000));
    vq.push_back(mk(3'b000,1,1,0, 0,3'b000,3'b000,3'b101));
    vq.push_back(mk(3'b000,1,1,0, 1,3'b100,3'b000,3'b101));
    vq.push_back(mk(3'b000,1,1,0, 0,3'b000,3'b100,3'b001));
    vq.push_back(mk(3'b000,1,1,0, 0,3'b000,3'b100,3'b001));
    vq.push_back(mk(3'b000,1,1,1, 0,3'b000,3'b000,3'b001));
    vq.push_back(mk(3'b000,1,0,0, 1,3'b001,3'b000,3'b001));
    vq.push_back(mk(3'b000,1,0,0, 1,3'b001,3'b000,3'b001));
    vq.push_back(mk(3'b000,0,0,0, 1,3'b001,3'b000,3'b001));
    vq.push_back(mk(3'b000,1,0,1, 1,3'b001,3'b000,3'b001));
    vq.push_back(mk(3'b000,1,0,0, 1,3'b001,3'b000,3'b001));
    vq.push_back(mk(3'b000,1,1,0, 0,3'b000,3'b001,3'b000));
    vq.push_back(mk(3'b000,1,1,1, 0,3'b000,3'b000,3'b000));
    // gie low holds a pending request
    vq.push_back(mk(3'b010,0,1,0, 0,3'b000,3'b000,3'b000));
    vq.push_back(mk(3'b000,0,1,0, 0,3'b000,3'b000,3'b000));
    vq.push_back(mk(3'b000,0,1,0, 0,3'b000,3'b000,3'b010));
    vq.push_back(mk(3'b000,0,1,0, 0,3'b000,3'b000,3'b010));
    vq.push_back(mk(3'b000,1,1,0, 1,3'b010,3'b000,3'b010));
    vq.push_back(mk(3'b000,1,1,0, 0,3'b000,3'b010,3'b000));
    vq.push_back(mk(3'b000,1,1,1, 0,3'b000,3'b000,3'b000));
    // held-high level pends only once
    vq.push_back(mk(3'b001,1,1,0, 0,3'b000,3'b000,3'b000));
    vq.push_back(mk(3'b001,1,1,0, 0,3'b000,3'b000,3'b000));
    vq.push_back(mk(3'b001,1,1,0, 0,3'b000,3'b000,3'b001));
    vq.push_back(mk(3'b001,1,1,0, 1,3'b001,3'b000,3'b001));
    vq.push_back(mk(3'b001,1,1,0, 0,3'b000,3'b001,3'b000));
    vq.push_back(mk(3'b001,1,1,0, 0,3'b000,3'b001,3'b000));
    vq.push_back(mk(3'b000,1,1,1, 0,3'b000,3'b000,3'b000));
    vq.push_back(mk(3'b000,1,1,1, 0,3'b000,3'b000,3'b000));

    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].irq, vq[i].gie, vq[i].pe, vq[i].uret);
      chk_all($sformatf("vec%0d", i),
              vq[i].en, vq[i].irs, vq[i].isv, vq[i].pend);
    end

    // preemption by a higher source while servicing source 0
    cyc(3'b001,1,1,0);
    cyc(3'b000,1,1,0);
    cyc(3'b000,1,1,0);
    cyc(3'b000,1,1,0);
    chk_all("nest.enter0", 1, 3'b001, 3'b000, 3'b001);
    cyc(3'b000,1,1,0);
    chk_all("nest.svc0", 0, 3'b000, 3'b001, 3'b000);
    cyc(3'b100,1,1,0);
    cyc(3'b000,1,1,0);
    cyc(3'b000,1,1,0);
    chk_all("nest.pend2", 0, 3'b000, 3'b001, 3'b100);
`ifdef INT_NEST_EN
    cyc(3'b000,1,1,0);
    chk_all("nest.enter2", 1, 3'b100, 3'b001, 3'b100);
    cyc(3'b000,1,1,0);
    chk_all("nest.svc2", 0, 3'b000, 3'b101, 3'b000);
    cyc(3'b000,1,1,1);
    chk_all("nest.uret1", 0, 3'b000, 3'b001, 3'b000);
    cyc(3'b000,1,1,1);
    chk_all("nest.uret2", 0, 3'b000, 3'b000, 3'b000);
    cyc(3'b000,1,1,0);
    chk_all("nest.idle", 0, 3'b000, 3'b000, 3'b000);
`else
    cyc(3'b000,1,1,0);
    chk_all("nonest.wait1", 0, 3'b000, 3'b001, 3'b100);
    cyc(3'b000,1,1,0);
    chk_all("nonest.wait2", 0, 3'b000, 3'b001, 3'b100);
    cyc(3'b000,1,1,1);
    chk_all("nonest.uret", 0, 3'b000, 3'b000, 3'b100);
    cyc(3'b000,1,1,0);
    chk_all("nonest.enter2", 1, 3'b100, 3'b000, 3'b100);
    cyc(3'b000,1,1,0);
    chk_all("nonest.svc2", 0, 3'b000, 3'b100, 3'b000);
    cyc(3'b000,1,1,1);
    chk_all("nonest.idle", 0, 3'b000, 3'b000, 3'b000);
`endif

    // async reset in the middle of ENTER
    cyc(3'b010,1,0,0);
    cyc(3'b000,1,0,0);
    cyc(3'b000,1,0,0);
    cyc(3'b000,1,0,0);
    chk_all("rst.enter", 1, 3'b010, 3'b000, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst.async", 0, 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3'b000,1,1,0);
    chk_all("rst.after", 0, 3'b000, 3'b000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
